// File: rtl/timer_wb_bridge_if.sv
// timer_wb_bridge_if: Wishbone bus between the CPU and the timer bridge.
interface timer_wb_bridge_if;
    logic [15:1] adr;
    logic [1:0]  sel;
    logic [15:0] datWr;
    logic [15:0] datRd;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    modport master (output adr, sel, datWr, we, stb, cyc, input datRd, ack);
    modport slave  (input adr, sel, datWr, we, stb, cyc, output datRd, ack);
endinterface

// File: rtl/timer_wb_bridge.sv
// timer_wb_bridge: Wishbone front end for the 8254 channels, port 0x61 and IRQ0.
module timer_wb_bridge #(
    parameter logic [15:1] PIT_WADR = 15'h0020,
    parameter logic [15:1] SPK_WADR = 15'h0030,
    parameter int          RD_HOLD  = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    timer_wb_bridge_if.slave wb,
    output logic [7:0]       cnt_dat_o,
    output logic             cnt_wrc_o,
    output logic [2:0]       cnt_wrd_o,
    output logic [2:0]       cnt_rdd_o,
    input  logic [7:0]       cnt0_dat_i,
    input  logic [7:0]       cnt1_dat_i,
    input  logic [7:0]       cnt2_dat_i,
    input  logic [2:0]       cnt_out_i,
    output logic [2:0]       cnt_gate_o,
    output logic             spk_o,
    output logic             irq0_o,
    input  logic             irq0_ack_i
);
    localparam int HW = $clog2(RD_HOLD + 1);
    typedef enum logic [1:0] {IDLE, P1, P2, ACK} stateT;
    stateT state, nextState;
    logic [15:1] adrR;
    logic [1:0] selR, off;
    logic [15:0] datR, rdData;
    logic [HW-1:0] holdCnt;
    logic [7:0] chByte;
    logic weR, ln, gate2, spkEn, o0d;
    logic start, pitLive, spkLive, pitR, spkR, isCh, holdLast, moreLanes, unusedOut1;
    assign start = wb.cyc && wb.stb && !wb.ack;
    assign pitLive = wb.adr == PIT_WADR || wb.adr == PIT_WADR + 15'd1;
    assign spkLive = wb.adr == SPK_WADR;
    assign pitR = adrR == PIT_WADR || adrR == PIT_WADR + 15'd1;
    assign spkR = adrR == SPK_WADR;
    assign off = {adrR[1], ln};
    assign isCh = pitR && off != 2'd3;
    assign holdLast = holdCnt == HW'(RD_HOLD - 2);
    assign moreLanes = !ln && selR[1];
    assign chByte = off == 2'd0 ? cnt0_dat_i : off == 2'd1 ? cnt1_dat_i : cnt2_dat_i;
    assign cnt_dat_o = ln ? datR[15:8] : datR[7:0];
    assign cnt_gate_o = {gate2, 2'b11};
    assign spk_o = cnt_out_i[2] && spkEn;
    assign wb.datRd = rdData;
    assign unusedOut1 = cnt_out_i[1];
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state <= IDLE;
        else state <= nextState;
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = (!(pitLive || spkLive) || wb.sel == 2'b00) ? ACK : P1;
            P1: nextState = (isCh && !weR) ? P2 : moreLanes ? P1 : ACK;
            P2: if (holdLast) nextState = moreLanes ? P1 : ACK;
            default: nextState = IDLE;
        endcase
    end
    always_comb begin
        wb.ack = state == ACK;
        cnt_wrc_o = state == P1 && weR && pitR && off == 2'd3;
        cnt_wrd_o = (state == P1 && weR && isCh) ? 3'(1) << off : 3'b000;
        cnt_rdd_o = ((state == P1 || state == P2) && !weR && isCh) ? 3'(1) << off : 3'b000;
    end
    // o0d resets high so an out0 already high at reset exit is not an edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            adrR <= '0;
            selR <= '0;
            weR <= 1'b0;
            datR <= '0;
            ln <= 1'b0;
            holdCnt <= '0;
            rdData <= 16'hFFFF;
            gate2 <= 1'b0;
            spkEn <= 1'b0;
            o0d <= 1'b1;
            irq0_o <= 1'b0;
        end else begin
            o0d <= cnt_out_i[0];
            irq0_o <= (cnt_out_i[0] && !o0d) || (irq0_o && !irq0_ack_i);
            case (state)
                IDLE: if (start) begin
                    adrR <= wb.adr;
                    selR <= wb.sel;
                    weR <= wb.we;
                    datR <= wb.datWr;
                    ln <= !wb.sel[0];
                    rdData <= 16'hFFFF;
                end
                P1: begin
                    holdCnt <= '0;
                    if (spkR && ln && weR) {spkEn, gate2} <= datR[9:8];
                    if (spkR && ln && !weR) rdData[15:8] <= {2'b00, cnt_out_i[2], 3'b000, spkEn, gate2};
                    if (!(isCh && !weR) && moreLanes) ln <= 1'b1;
                end
                P2: begin
                    holdCnt <= holdCnt + 1'b1;
                    if (holdLast) begin
                        rdData[{ln, 3'b000} +: 8] <= chByte;
                        if (moreLanes) ln <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_wb_bridge.sv
// tb_timer_wb_bridge: directed and random bus accesses checked against a lane-level model.
module tb_timer_wb_bridge;
    localparam logic [15:1] PIT = 15'h0020;
    localparam logic [15:1] SPK = 15'h0030;
    localparam int RDH = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] cntDatO;
    logic wrc, irq, irqAck = 1'b0, spk;
    logic [2:0] wrd, rdd, gate, cntOut = 3'b101;
    logic [7:0] cnt [3];
    int vectors = 0, miscompares = 0;
    logic spkEnM = 1'b0, gate2M = 1'b0;
    always #5 clk = ~clk;
    timer_wb_bridge_if wb();
    timer_wb_bridge #(.PIT_WADR(PIT), .SPK_WADR(SPK), .RD_HOLD(RDH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb.slave),
        .cnt_dat_o(cntDatO), .cnt_wrc_o(wrc), .cnt_wrd_o(wrd), .cnt_rdd_o(rdd),
        .cnt0_dat_i(cnt[0]), .cnt1_dat_i(cnt[1]), .cnt2_dat_i(cnt[2]),
        .cnt_out_i(cntOut), .cnt_gate_o(gate), .spk_o(spk),
        .irq0_o(irq), .irq0_ack_i(irqAck)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // One bus access; expectations come from the lane rules, observations from the pins.
    task automatic xfer(input logic [15:1] a, input logic [1:0] s, input logic w,
                        input logic [15:0] d, input logic drop, input string tag);
        logic [11:0] expEv[$];
        logic [11:0] gotEv[$];
        int expRdd[3];
        int gotRdd[3];
        int expLat, lat, ovl;
        logic [15:0] expRd, gotRd;
        logic pit, spkHit, miss;
        logic [1:0] o, wi;
        logic [7:0] b;
        pit = a == PIT || a == PIT + 15'd1;
        spkHit = a == SPK;
        miss = !(pit || spkHit) || s == 2'b00;
        expLat = 1;
        expRd = 16'hFFFF;
        expRdd = '{0, 0, 0};
        gotRdd = '{0, 0, 0};
        if (!miss) for (int l = 0; l < 2; l++) if (s[l]) begin
            o = {a[1], l[0]};
            b = d[8*l +: 8];
            expLat++;
            if (pit && o != 2'd3) begin
                if (w) expEv.push_back({2'd1, o, b});
                else begin
                    expRdd[o] = RDH;
                    expRd[8*l +: 8] = cnt[o];
                    expLat += RDH - 1;
                end
            end else if (pit) begin
                if (w) expEv.push_back({2'd2, 2'd0, b});
            end else if (l == 1) begin
                if (w) {spkEnM, gate2M} = b[1:0];
                else expRd[15:8] = {2'b00, cntOut[2], 3'b000, spkEnM, gate2M};
            end
        end
        @(negedge clk);
        wb.adr = a; wb.sel = s; wb.we = w; wb.datWr = d; wb.cyc = 1'b1; wb.stb = 1'b1;
        lat = 0;
        ovl = 0;
        gotRd = 16'hxxxx;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (drop) begin wb.cyc = 1'b0; wb.stb = 1'b0; end
            wi = wrd[2] ? 2'd2 : wrd[1] ? 2'd1 : 2'd0;
            if (wrd != 3'b000) gotEv.push_back({2'd1, wi, cntDatO});
            if (wrc) gotEv.push_back({2'd2, 2'd0, cntDatO});
            if (!$onehot0(wrd) || !$onehot0(rdd) || (rdd != 3'b000 && (wrd != 3'b000 || wrc))) ovl++;
            for (int c = 0; c < 3; c++) gotRdd[c] += int'(rdd[c]);
            if (wb.ack) begin
                lat = n;
                gotRd = wb.datRd;
                break;
            end
        end
        wb.cyc = 1'b0; wb.stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " ack one cycle"}, 32'(wb.ack), 32'd0);
        chk({tag, " latency"}, lat, expLat);
        chk({tag, " strobe overlap"}, ovl, 0);
        chk({tag, " write events"}, gotEv.size(), expEv.size());
        for (int i = 0; i < gotEv.size() && i < expEv.size(); i++) chk({tag, " write event"}, 32'(gotEv[i]), 32'(expEv[i]));
        for (int c = 0; c < 3; c++) chk({tag, " rdd cycles"}, gotRdd[c], expRdd[c]);
        if (!w) chk({tag, " read data"}, 32'(gotRd), 32'(expRd));
        chk({tag, " gates"}, 32'(gate), 32'({gate2M, 2'b11}));
        chk({tag, " speaker"}, 32'(spk), 32'(cntOut[2] & spkEnM));
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        logic [15:1] a;
        wb.adr = '0; wb.sel = '0; wb.we = 1'b0; wb.datWr = '0; wb.cyc = 1'b0; wb.stb = 1'b0;
        cnt = '{8'h00, 8'h00, 8'h00};
        repeat (2) @(negedge clk);
        chk("rst ack", 32'(wb.ack), 32'd0);
        chk("rst dat", 32'(wb.datRd), 32'hFFFF);
        chk("rst strobes", 32'({wrc, wrd, rdd}), 32'd0);
        chk("rst cnt_dat", 32'(cntDatO), 32'd0);
        chk("rst gates", 32'(gate), 32'b011);
        chk("rst speaker", 32'(spk), 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no spurious irq", 32'(irq), 32'd0);
        cntOut = 3'b000;
        xfer(PIT + 15'd1, 2'b10, 1'b1, 16'h3600, 1'b0, "wr43");
        xfer(PIT, 2'b11, 1'b1, 16'h1234, 1'b0, "wr40 word");
        cnt[2] = 8'hA5;
        xfer(PIT + 15'd1, 2'b01, 1'b0, 16'h0000, 1'b0, "rd42");
        chk("rd42 literal", 32'(wb.datRd), 32'hFFA5);
        cntOut[2] = 1'b1;
        xfer(SPK, 2'b10, 1'b1, 16'h0300, 1'b0, "wr61");
        chk("wr61 gates literal", 32'(gate), 32'b111);
        xfer(SPK, 2'b10, 1'b0, 16'h0000, 1'b0, "rd61");
        chk("rd61 literal", 32'(wb.datRd), 32'h23FF);
        xfer(15'h0100, 2'b11, 1'b1, 16'hBEEF, 1'b0, "miss");
        xfer(PIT, 2'b00, 1'b0, 16'h0000, 1'b0, "sel none");
        cnt[0] = 8'h5A; cnt[1] = 8'hC3;
        xfer(PIT, 2'b11, 1'b0, 16'h0000, 1'b1, "cyc drop word read");
        @(negedge clk); cntOut[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("irq idle", 32'(irq), 32'd0);
        cntOut[0] = 1'b1;
        @(negedge clk);
        chk("irq rise", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq level", 32'(irq), 32'd1);
        irqAck = 1'b1;
        @(negedge clk);
        irqAck = 1'b0;
        chk("irq ack", 32'(irq), 32'd0);
        cntOut[0] = 1'b0;
        @(negedge clk);
        cntOut[0] = 1'b1; irqAck = 1'b1;
        @(negedge clk);
        irqAck = 1'b0;
        chk("irq set beats ack", 32'(irq), 32'd1);
        irqAck = 1'b1;
        @(negedge clk);
        irqAck = 1'b0;
        chk("irq ack again", 32'(irq), 32'd0);
        wb.adr = PIT; wb.sel = 2'b01; wb.we = 1'b0; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort rdd P1", 32'(rdd), 32'b001);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        @(posedge clk);
        #2;
        chk("abort rdd P2", 32'(rdd), 32'b001);
        rst = 1'b1;
        #1;
        chk("abort rdd drop", 32'(rdd), 32'd0);
        chk("abort no ack", 32'(wb.ack), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spkEnM = 1'b0; gate2M = 1'b0;
        chk("abort gates", 32'(gate), 32'b011);
        chk("abort dat", 32'(wb.datRd), 32'hFFFF);
        cnt[0] = 8'h3C;
        xfer(PIT, 2'b01, 1'b0, 16'h0000, 1'b0, "after abort");
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: a = PIT;
                1: a = PIT + 15'd1;
                2: a = SPK;
                3: a = 15'($urandom);
                default: a = PIT;
            endcase
            for (int c = 0; c < 3; c++) cnt[c] = 8'($urandom);
            cntOut[2] = 1'($urandom);
            xfer(a, 2'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
